// File: rtl/ed25519_pkg.sv
// -----------------------------------------------------------------------------
// ed25519_pkg
//   Shared constants and types for the Ed25519 arithmetic blocks: the
//   multiplier (seq_mult_256bit), the sequential reducer (seq_mod_reduce)
//   and their benches.
//
//   B        operand/result width (257 bits)
//   B2       full product width (514 bits, always 2*B)
//   CNT_W    width of the reducer's bit counter (covers 0..B2-1)
//   Q_PRIME  field prime q = 2^255 - 19 (255 bits)
//   L_ORDER  group order l = 2^252 + 27742317777372353535851937790883648493 (253 bits)
//   state_t  IDLE / RUN / DONE control state shared by the sequential blocks
// -----------------------------------------------------------------------------
package ed25519_pkg;

   localparam int B     = 257;
   localparam int B2    = 2 * B;
   localparam int CNT_W = 10;

   localparam logic [254:0] Q_PRIME =
      255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

   localparam logic [252:0] L_ORDER =
      253'h10000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Modulus selected by mod_sel, zero-extended to the working width.
   function automatic logic [B-1:0] sel_modulus(input logic i_sel);
      return i_sel ? {{(B-253){1'b0}}, L_ORDER} : {{(B-255){1'b0}}, Q_PRIME};
   endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// -----------------------------------------------------------------------------
// mod_cond_sub
//   Combinational conditional subtract: o_r = (i_t >= i_m) ? i_t - i_m : i_t.
//   One step of restoring reduction. When i_t < 2*i_m, the output is the
//   fully reduced value.
//
//   i_t  [B-1:0]  partial remainder, shifted and carrying the next product bit
//   i_m  [B-1:0]  modulus
//   o_r  [B-1:0]  conditionally reduced value
// -----------------------------------------------------------------------------
module mod_cond_sub
   import ed25519_pkg::*;
(
   input  logic [B-1:0] i_t,
   input  logic [B-1:0] i_m,
   output logic [B-1:0] o_r
);

   logic [B-1:0] w_diff;
   logic         w_ge;

   assign w_ge   = (i_t >= i_m);
   assign w_diff = i_t - i_m;
   assign o_r    = w_ge ? w_diff : i_t;

endmodule

// File: rtl/seq_mod_reduce.sv
// -----------------------------------------------------------------------------
// seq_mod_reduce
//   Bit-serial restoring reducer. It takes the 514-bit product from
//   seq_mult_256bit and returns product mod M, where M is q (mod_sel=0) or
//   l (mod_sel=1). Each RUN cycle consumes one product bit, MSB first:
//   r <- cond_sub({r, bit}, M). The remainder stays below M after every step.
//
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; aborts any operation in flight
//   start      in   request; only acted on in IDLE or DONE
//   product    in   [B2-1:0] value to reduce; captured on the accepting edge
//   mod_sel    in   modulus select; captured with product
//   result     out  [B-1:0] product mod M; held from done until the next result
//   done       out  one-cycle pulse marking a fresh result
//   busy       out  high throughout RUN
//   dbg_state  out  current control state
//
//   Handshake: start is sampled on a rising edge while the block is in IDLE or
//   DONE. That edge accepts the request, and the block captures product and
//   mod_sel on it. A start seen during RUN is dropped and is not remembered.
//   The result is ready 514 edges after acceptance, when done is high for
//   exactly one cycle. Asserting start in that DONE cycle begins the next
//   reduction with no idle cycle in between.
// -----------------------------------------------------------------------------
module seq_mod_reduce
   import ed25519_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [B2-1:0] product,
   input  logic          mod_sel,
   output logic [B-1:0]  result,
   output logic          done,
   output logic          busy,
   output state_t        dbg_state
);

   state_t           r_state;
   state_t           w_next_state;
   logic             w_accept;
   logic             w_last;

   logic [CNT_W-1:0] r_cnt;
   logic [B2-1:0]    r_prod_q;
   logic [B-1:0]     r_m_q;
   logic [B-1:0]     r_r;
   logic [B-1:0]     r_result;
   logic             r_done;
   logic             r_busy;

   logic [B-1:0]     w_t;
   logic [B-1:0]     w_r_next;

   // r < M < 2^255, so the top bit of r is always zero. Dropping it from the
   // shift loses nothing.
   logic             w_unused_r_msb;
   assign w_unused_r_msb = r_r[B-1];

   // ---------------------------------------------------------------------
   // Control FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM: next state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            // start is deliberately not looked at here.
            if (r_cnt == '0) begin
               w_last       = 1'b1;
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end else begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Reduction step. The product is kept left-aligned and shifted every RUN
   // cycle, so the bit being consumed is always the MSB of r_prod_q.
   // ---------------------------------------------------------------------
   assign w_t = {r_r[B-2:0], r_prod_q[B2-1]};

   mod_cond_sub u_cond_sub (
      .i_t (w_t),
      .i_m (r_m_q),
      .o_r (w_r_next)
   );

   // ---------------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_prod_q <= '0;
         r_m_q    <= '0;
         r_r      <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_prod_q <= product;
            r_m_q    <= sel_modulus(mod_sel);
            r_r      <= '0;
            r_cnt    <= CNT_W'(B2 - 1);
            r_busy   <= 1'b1;
         end else if (r_state == RUN) begin
            r_prod_q <= r_prod_q << 1;
            r_r      <= w_r_next;
            if (w_last) begin
               r_result <= w_r_next;
               r_busy   <= 1'b0;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   assign result    = r_result;
   assign done      = r_done;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mod_reduce.sv
module tb_seq_mod_reduce;
   import ed25519_pkg::*;

   // ---------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------
   logic          clk;
   logic          rst_n;
   logic          start;
   logic [B2-1:0] product;
   logic          mod_sel;
   logic [B-1:0]  result;
   logic          done;
   logic          busy;
   state_t        dbg_state;

   int checks;
   int failures;

   localparam logic [B-1:0] Q_W = {2'b0, Q_PRIME};
   localparam logic [B-1:0] L_W = {4'b0, L_ORDER};

   seq_mod_reduce dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .product   (product),
      .mod_sel   (mod_sel),
      .result    (result),
      .done      (done),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Golden model: plain wide modulo.
   function automatic logic [B-1:0] golden(input logic [B2-1:0] p, input logic sel);
      logic [B2-1:0] m;
      logic [B2-1:0] tmp;
      m   = sel ? {{(B2-253){1'b0}}, L_ORDER} : {{(B2-255){1'b0}}, Q_PRIME};
      tmp = p % m;
      return tmp[B-1:0];
   endfunction

   function automatic logic [B2-1:0] rand_product();
      logic [B2-1:0] p;
      p = '0;
      for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom();
      p[B2-1 -: 2] = 2'($urandom_range(0, 3));
      return p;
   endfunction

   // ---------------------------------------------------------------
   // Driver tasks (called off the clock edge; they return #1 after an edge)
   // ---------------------------------------------------------------
   task automatic launch(input logic [B2-1:0] p, input logic sel);
      start   = 1'b1;
      product = p;
      mod_sel = sel;
      @(posedge clk);
      #1;
      start   = 1'b0;
      product = ~p;     // scribble the inputs to show they were captured
      mod_sel = ~sel;
   endtask

   // Waits for done with a bound. lat counts edges after the accepting edge.
   task automatic wait_done(output logic [B-1:0] res, output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && lat < 600) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busy_cnt++;
      end
      res = result;
   endtask

   // ---------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------
   task automatic test_reset();
      rst_n   = 1'b0;
      start   = 1'b0;
      product = '0;
      mod_sel = 1'b0;
      #3;
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero();
      logic [B-1:0] res;
      int lat, bc;
      launch('0, 1'b0);
      checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL zero_enter_run got=%0d exp=%0d", dbg_state, RUN); end
      wait_done(res, lat, bc);
      checks++; if (res !== '0) begin failures++; $display("FAIL zero_result got=%h exp=0", res); end
      checks++; if (lat !== 514) begin failures++; $display("FAIL zero_latency got=%0d exp=514", lat); end
      checks++; if (bc !== 514) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=514", bc); end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL zero_back_idle got=%0d exp=%0d", dbg_state, IDLE); end
   endtask

   task automatic test_boundaries();
      logic [B2-1:0] vp[6];
      logic          vs[6];
      logic [B-1:0]  ve[6];
      logic [B-1:0]  res;
      int lat, bc;
      vp[0] = {257'b0, Q_W + 257'd5}; vs[0] = 1'b0; ve[0] = 257'd5;
      vp[1] = {257'b0, L_W};          vs[1] = 1'b1; ve[1] = '0;
      vp[2] = {257'b0, Q_W - 257'd1}; vs[2] = 1'b0; ve[2] = Q_W - 257'd1;
      vp[3] = {257'b0, Q_W};          vs[3] = 1'b0; ve[3] = '0;
      vp[4] = {257'b0, L_W - 257'd1}; vs[4] = 1'b1; ve[4] = L_W - 257'd1;
      vp[5] = '1;                     vs[5] = 1'b1; ve[5] = golden('1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         launch(vp[i], vs[i]);
         wait_done(res, lat, bc);
         checks++; if (res !== ve[i]) begin failures++; $display("FAIL boundary_%0d result got=%h exp=%h", i, res, ve[i]); end
         checks++; if (lat !== 514) begin failures++; $display("FAIL boundary_%0d latency got=%0d exp=514", i, lat); end
      end
   endtask

   task automatic test_square();
      logic [B2-1:0] x;
      logic [B2-1:0] p;
      logic [B-1:0]  res, exp_v;
      int lat, bc;
      x = {257'b0, 257'd52424661395467705593862908645031544692223933496118405275236336510276532625785};
      p = x * x;
      for (int s = 0; s < 2; s++) begin
         exp_v = golden(p, s[0]);
         launch(p, s[0]);
         wait_done(res, lat, bc);
         checks++; if (res !== exp_v) begin failures++; $display("FAIL square_sel%0d got=%h exp=%h", s, res, exp_v); end
      end
   endtask

   task automatic test_random();
      logic [B2-1:0] p;
      logic [B-1:0]  res, exp_v;
      int lat, bc;
      for (int i = 0; i < 20; i++) begin
         p     = rand_product();
         exp_v = golden(p, i[0]);
         launch(p, i[0]);
         wait_done(res, lat, bc);
         checks++; if (res !== exp_v) begin failures++; $display("FAIL random_%0d got=%h exp=%h", i, res, exp_v); end
      end
   endtask

   task automatic test_back_to_back();
      logic [B2-1:0] pa, pb;
      logic [B-1:0]  res, exp_a, exp_b;
      int lat;
      pa = rand_product();
      pb = rand_product();
      exp_a = golden(pa, 1'b0);
      exp_b = golden(pb, 1'b1);
      launch(pa, 1'b0);
      // A start pulse in the middle of RUN, with a different product, must be dropped.
      lat = 0;
      while (!done && lat < 600) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 100) begin start = 1'b1; product = pb; mod_sel = 1'b1; end
         if (lat == 101) begin start = 1'b0; product = ~pb; mod_sel = 1'b0; end
      end
      checks++; if (result !== exp_a) begin failures++; $display("FAIL ignore_start result got=%h exp=%h", result, exp_a); end
      checks++; if (lat !== 514) begin failures++; $display("FAIL ignore_start latency got=%0d exp=514", lat); end
      // Issue the next request during the DONE cycle itself.
      launch(pb, 1'b1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL b2b_state got=%0d exp=%0d", dbg_state, RUN); end
      checks++; if (result !== exp_a) begin failures++; $display("FAIL b2b_result_held got=%h exp=%h", result, exp_a); end
      begin
         int bc;
         wait_done(res, lat, bc);
      end
      checks++; if (res !== exp_b) begin failures++; $display("FAIL b2b_result got=%h exp=%h", res, exp_b); end
      checks++; if (lat !== 514) begin failures++; $display("FAIL b2b_latency got=%0d exp=514", lat); end
   endtask

   task automatic test_reset_mid_run();
      logic [B2-1:0] pc, pd;
      logic [B-1:0]  res, exp_d;
      int lat, bc, seen;
      pc = rand_product();
      pd = rand_product();
      exp_d = golden(pd, 1'b0);
      launch(pc, 1'b1);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result got=%h exp=0", result); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, IDLE); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 520; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
      launch(pd, 1'b0);
      wait_done(res, lat, bc);
      checks++; if (res !== exp_d) begin failures++; $display("FAIL midrst_after got=%h exp=%h", res, exp_d); end
      checks++; if (lat !== 514) begin failures++; $display("FAIL midrst_after_latency got=%0d exp=514", lat); end
   endtask

   // ---------------------------------------------------------------
   // Sequence and final report
   // ---------------------------------------------------------------
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_zero();
      test_boundaries();
      test_square();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
